// File: rtl/nn_acc_pkg.sv
// Shared definitions for the NN MAC responder: register word addresses, CTRL/STATUS
// bit positions and the run-sequencer state encoding.
package nn_acc_pkg;

    // Word addresses on the Avalon-MM slave port
    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h01;
    localparam logic [7:0] ADDR_LEN    = 8'h02;
    localparam logic [7:0] ADDR_RESULT = 8'h03;
    localparam logic [7:0] X_BASE      = 8'h40;
    localparam logic [7:0] W_BASE      = 8'h80;

    // CTRL bits
    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_RELU  = 1;
    localparam int unsigned CTRL_IE    = 2;

    // STATUS bits
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRun,
        StDrain,
        StDoneSt
    } nn_state_e;

endpackage

// File: rtl/nn_mac_datapath.sv
// Pipelined signed MAC with output scaling.
//   clk, reset : system clock, synchronous active-high reset
//   clr        : clears product and accumulator at the start of a run
//   en         : x/w hold a valid buffer pair this cycle
//   x, w       : signed DATA_W operands (registered buffer outputs)
//   relu       : clamp negative results to zero
//   result     : acc >>> FRAC, saturated to signed 32 bits, optional ReLU (combinational)
module nn_mac_datapath #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    input  logic              relu,
    output logic [31:0]       result
);

    localparam int unsigned PW = 2 * DATA_W;

    logic signed [PW-1:0]    x_ext, w_ext, prod_d, prod_q;
    logic                    prod_vld_q;
    logic signed [ACC_W-1:0] acc_d, acc_q, shifted;
    logic [31:0]             sat;

    assign x_ext  = {{DATA_W{x[DATA_W-1]}}, x};
    assign w_ext  = {{DATA_W{w[DATA_W-1]}}, w};
    assign prod_d = x_ext * w_ext;
    assign acc_d  = acc_q + {{(ACC_W - PW){prod_q[PW-1]}}, prod_q};

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            if (en) begin
                prod_q <= prod_d;
            end
            prod_vld_q <= en;
            // Accumulate the product captured one cycle earlier
            if (prod_vld_q) begin
                acc_q <= acc_d;
            end
        end
    end

    assign shifted = acc_q >>> FRAC;

    always_comb begin
        // Fits in 32 bits only when every bit from 31 upward equals the sign
        if ((&shifted[ACC_W-1:31]) || !(|shifted[ACC_W-1:31])) begin
            sat = shifted[31:0];
        end else if (shifted[ACC_W-1]) begin
            sat = 32'h8000_0000;
        end else begin
            sat = 32'h7fff_ffff;
        end
        result = (relu && sat[31]) ? 32'h0 : sat;
    end

endmodule

// File: rtl/nn_mac_slave.sv
// Avalon-MM responder holding X/W vectors and computing a fixed-point dot product.
//   clk, reset                 : system clock, synchronous active-high reset
//   address, chipselect        : word address and slave select
//   read, write, writedata     : access strobes and write data
//   readdata                   : read data, valid the cycle after the read
//   irq                        : level interrupt, DONE & IE
module nn_mac_slave
    import nn_acc_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned ACC_W  = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [8:0] XLo = {1'b0, X_BASE};
    localparam logic [8:0] XHi = XLo + 9'(DEPTH);
    localparam logic [8:0] WLo = {1'b0, W_BASE};
    localparam logic [8:0] WHi = WLo + 9'(DEPTH);

    nn_state_e   state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic        drain_q, drain_d;
    logic        issue_q, issue_d;
    logic [8:0]  len_q, len_d;
    logic        relu_q, relu_d, ie_q, ie_d, done_q, done_d;
    logic [31:0] result_q, result_d, rdata_q, rdata_d;
    logic        rsel_x_q, rsel_x_d, rsel_w_q, rsel_w_d;

    logic        busy, wr_acc, rd_acc, x_hit, w_hit, start_acc, dp_clr, set_done;
    logic [AW-1:0] x_off, w_off, x_raddr, w_raddr;
    logic [31:0] dp_result;
    logic        unused_wdata;

    logic [DATA_W-1:0] x_mem [DEPTH];
    logic [DATA_W-1:0] w_mem [DEPTH];
    logic [DATA_W-1:0] x_rd_q, w_rd_q;

    assign unused_wdata = ^writedata[31:DATA_W];

    assign busy   = (state_q != StIdle);
    assign wr_acc = chipselect && write;
    // A combined read+write counts only as a write
    assign rd_acc = chipselect && read && !write;
    assign x_hit  = ({1'b0, address} >= XLo) && ({1'b0, address} < XHi);
    assign w_hit  = ({1'b0, address} >= WLo) && ({1'b0, address} < WHi);
    assign x_off  = AW'(address - X_BASE);
    assign w_off  = AW'(address - W_BASE);

    assign start_acc = wr_acc && (address == ADDR_CTRL) && writedata[CTRL_START] && !busy;

    // The single read port belongs to the sequencer while busy, to the bus otherwise
    assign x_raddr = busy ? idx_q : x_off;
    assign w_raddr = busy ? idx_q : w_off;

    always_ff @(posedge clk) begin
        if (wr_acc && !busy && x_hit) begin
            x_mem[x_off] <= writedata[DATA_W-1:0];
        end
        if (wr_acc && !busy && w_hit) begin
            w_mem[w_off] <= writedata[DATA_W-1:0];
        end
        x_rd_q <= x_mem[x_raddr];
        w_rd_q <= w_mem[w_raddr];
    end

    // Run sequencer
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drain_d  = 1'b0;
        issue_d  = 1'b0;
        dp_clr   = 1'b0;
        set_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    dp_clr  = 1'b1;
                    idx_d   = '0;
                    state_d = (len_q == 9'd0) ? StDoneSt : StFill;
                end
            end
            StFill: begin
                issue_d = 1'b1;
                idx_d   = idx_q + AW'(1);
                state_d = (len_q == 9'd1) ? StDrain : StRun;
            end
            StRun: begin
                issue_d = 1'b1;
                idx_d   = idx_q + AW'(1);
                if (9'(idx_q) == len_q - 9'd1) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Two cycles: one for the product stage, one for the accumulate stage
                drain_d = 1'b1;
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = StDoneSt;
                end
            end
            StDoneSt: begin
                set_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Register file
    always_comb begin
        len_d    = len_q;
        relu_d   = relu_q;
        ie_d     = ie_q;
        done_d   = done_q;
        result_d = result_q;
        if (wr_acc && address == ADDR_CTRL) begin
            ie_d = writedata[CTRL_IE];
            if (!busy) begin
                relu_d = writedata[CTRL_RELU];
            end
        end
        if (wr_acc && address == ADDR_LEN && !busy) begin
            len_d = (writedata[8:0] > 9'(DEPTH)) ? 9'(DEPTH) : writedata[8:0];
        end
        if (start_acc) begin
            done_d = 1'b0;
        end
        if (rd_acc && address == ADDR_STATUS) begin
            done_d = 1'b0;
        end
        // Completion beats a coincident STATUS-read clear
        if (set_done) begin
            done_d   = 1'b1;
            result_d = dp_result;
        end
    end

    // Read data path; buffer reads while busy return 0 since the port is in use
    always_comb begin
        rdata_d  = '0;
        rsel_x_d = 1'b0;
        rsel_w_d = 1'b0;
        if (rd_acc) begin
            if (address == ADDR_CTRL) begin
                rdata_d[CTRL_RELU] = relu_q;
                rdata_d[CTRL_IE]   = ie_q;
            end else if (address == ADDR_STATUS) begin
                rdata_d[STAT_BUSY] = busy;
                rdata_d[STAT_DONE] = done_q;
            end else if (address == ADDR_LEN) begin
                rdata_d[8:0] = len_q;
            end else if (address == ADDR_RESULT) begin
                rdata_d = result_q;
            end else if (x_hit && !busy) begin
                rsel_x_d = 1'b1;
            end else if (w_hit && !busy) begin
                rsel_w_d = 1'b1;
            end
        end
    end

    always_comb begin
        if (rsel_x_q) begin
            readdata = {{(32 - DATA_W){x_rd_q[DATA_W-1]}}, x_rd_q};
        end else if (rsel_w_q) begin
            readdata = {{(32 - DATA_W){w_rd_q[DATA_W-1]}}, w_rd_q};
        end else begin
            readdata = rdata_q;
        end
    end

    assign irq = done_q && ie_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            drain_q  <= 1'b0;
            issue_q  <= 1'b0;
            len_q    <= '0;
            relu_q   <= 1'b0;
            ie_q     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rdata_q  <= '0;
            rsel_x_q <= 1'b0;
            rsel_w_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            drain_q  <= drain_d;
            issue_q  <= issue_d;
            len_q    <= len_d;
            relu_q   <= relu_d;
            ie_q     <= ie_d;
            done_q   <= done_d;
            result_q <= result_d;
            rdata_q  <= rdata_d;
            rsel_x_q <= rsel_x_d;
            rsel_w_q <= rsel_w_d;
        end
    end

    nn_mac_datapath #(
        .DATA_W(DATA_W),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_datapath (
        .clk   (clk),
        .reset (reset),
        .clr   (dp_clr),
        .en    (issue_q),
        .x     (x_rd_q),
        .w     (w_rd_q),
        .relu  (relu_q),
        .result(dp_result)
    );

endmodule

// File: tb/tb_nn_mac_slave.sv
// Bench for nn_mac_slave: two instances (FRAC=8 and FRAC=0) share one bus; a
// transaction-level model predicts readdata and irq for both every cycle.
module tb_nn_mac_slave;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset, cs, rd, wr;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata8, rdata0;
    logic        irq8, irq0;

    always #10 clk = ~clk;

    nn_mac_slave #(.DEPTH(64), .DATA_W(16), .FRAC(8), .ACC_W(40)) u_dut (
        .clk(clk), .reset(reset), .address(addr), .chipselect(cs), .read(rd),
        .write(wr), .writedata(wdata), .readdata(rdata8), .irq(irq8)
    );

    nn_mac_slave #(.DEPTH(64), .DATA_W(16), .FRAC(0), .ACC_W(40)) u_dut_f0 (
        .clk(clk), .reset(reset), .address(addr), .chipselect(cs), .read(rd),
        .write(wr), .writedata(wdata), .readdata(rdata0), .irq(irq0)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    shortint     mx [DEPTH];
    shortint     mw [DEPTH];
    int          m_len;
    bit          m_relu, m_ie, m_done, m_run, m_live;
    longint      m_edge, m_done_edge;
    logic [31:0] m_res8, m_res0, exp8, exp0;
    bit          exp_vld;

    function automatic logic [31:0] model_result(input int frac);
        longint acc;
        acc = 0;
        for (int i = 0; i < m_len; i++) acc += longint'(mx[i]) * longint'(mw[i]);
        acc = acc >>> frac;
        if (acc > 64'sd2147483647) acc = 64'sd2147483647;
        if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        if (m_relu && acc < 0) acc = 0;
        return acc[31:0];
    endfunction

    initial begin
        m_edge = 0; m_live = 0; exp_vld = 0; m_run = 0;
        forever begin
            bit rda, wra, busy;
            int v;
            @(posedge clk);
            m_edge++;
            if (reset) begin
                m_len = 0; m_relu = 0; m_ie = 0; m_done = 0; m_run = 0;
                m_res8 = 0; m_res0 = 0;
                exp_vld = 1; exp8 = 0; exp0 = 0; m_live = 1;
            end else if (m_live) begin
                rda  = cs && rd && !wr;
                wra  = cs && wr;
                busy = m_run;
                exp_vld = 0;
                if (cs && rd && wr) begin
                    exp_vld = 1; exp8 = 0; exp0 = 0;
                end else if (rda) begin
                    exp_vld = 1; exp8 = 0;
                    if (addr == 8'h00) exp8 = {29'd0, m_ie, m_relu, 1'b0};
                    else if (addr == 8'h01) exp8 = {30'd0, m_done, busy};
                    else if (addr == 8'h02) exp8 = m_len;
                    else if (addr >= 8'h40 && addr < 8'h80) begin
                        if (busy) exp_vld = 0;
                        else exp8 = 32'(int'(mx[addr - 8'h40]));
                    end else if (addr >= 8'h80 && addr < 8'hC0) begin
                        if (busy) exp_vld = 0;
                        else exp8 = 32'(int'(mw[addr - 8'h80]));
                    end
                    exp0 = exp8;
                    if (addr == 8'h03) begin exp8 = m_res8; exp0 = m_res0; end
                end
                if (wra) begin
                    if (addr == 8'h00) begin
                        m_ie = wdata[2];
                        if (!busy) begin
                            m_relu = wdata[1];
                            if (wdata[0]) begin
                                m_run = 1; m_done = 0;
                                m_done_edge = m_edge + ((m_len == 0) ? 1 : m_len + 3);
                            end
                        end
                    end else if (!busy) begin
                        if (addr == 8'h02) begin
                            v = int'(wdata[8:0]);
                            m_len = (v > DEPTH) ? DEPTH : v;
                        end else if (addr >= 8'h40 && addr < 8'h80) mx[addr - 8'h40] = wdata[15:0];
                        else if (addr >= 8'h80 && addr < 8'hC0) mw[addr - 8'h80] = wdata[15:0];
                    end
                end
                if (rda && addr == 8'h01) m_done = 0;
                if (m_run && m_edge == m_done_edge) begin
                    m_run = 0; m_done = 1;
                    m_res8 = model_result(8);
                    m_res0 = model_result(0);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                if (exp_vld) begin
                    check("readdata", rdata8, exp8);
                    check("readdata_f0", rdata0, exp0);
                end
                check("irq", {31'd0, irq8}, {31'd0, m_done && m_ie});
                check("irq_f0", {31'd0, irq0}, {31'd0, m_done && m_ie});
            end
        end
    end

    // ---------------- bus tasks ----------------
    task automatic bus_cyc(input bit c, input bit r, input bit w, input logic [7:0] a,
                           input logic [31:0] d);
        cs = c; rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        cs = 0; rd = 0; wr = 0;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        bus_cyc(1, 0, 1, a, d);
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d8, output logic [31:0] d0);
        bus_cyc(1, 1, 0, a, 32'd0);
        d8 = rdata8; d0 = rdata0;
    endtask

    task automatic wait_done(input string name);
        logic [31:0] s8, s0;
        s8 = 0;
        for (int k = 0; k < 300; k++) begin
            bus_rd(8'h01, s8, s0);
            if (s8[1]) break;
        end
        check(name, s8 & 32'h2, 32'h2);
    endtask

    task automatic idle(input int n);
        repeat (n) bus_cyc(0, 0, 0, 8'h00, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d8, d0, s8;
        int nbusy, r, xv[4];
        logic [7:0] a;
        xv = '{256, 512, -256, 1024};
        reset = 1; cs = 0; rd = 0; wr = 0; addr = 0; wdata = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Reset readback
        bus_rd(8'h01, d8, d0); check("rst_status", d8, 0);
        bus_rd(8'h03, d8, d0); check("rst_result", d8, 0);
        bus_rd(8'h02, d8, d0); check("rst_len", d8, 0);
        check("rst_irq", {31'd0, irq8}, 0);

        // Basic dot product
        bus_wr(8'h02, 4);
        for (int i = 0; i < 4; i++) begin
            bus_wr(8'h40 + 8'(i), xv[i]);
            bus_wr(8'h80 + 8'(i), 256);
        end
        bus_wr(8'h00, 32'h1);
        nbusy = 0; s8 = 32'hdead;
        for (int k = 0; k < 20; k++) begin
            bus_rd(8'h01, d8, d0);
            if (d8[0]) nbusy++;
            else begin s8 = d8; break; end
        end
        check("busy_cycles", nbusy, 7);
        check("done_status", s8, 32'h2);
        bus_rd(8'h01, d8, d0); check("done_cleared", d8, 0);
        bus_rd(8'h03, d8, d0);
        check("basic_result", d8, 1536);
        check("basic_result_f0", d0, 393216);
        bus_rd(8'h42, d8, d0); check("x2_readback", d8, 32'hffff_ff00);

        // ReLU
        for (int i = 0; i < 4; i++) bus_wr(8'h80 + 8'(i), 32'hffff_ff00);
        bus_wr(8'h00, 32'h1);
        wait_done("relu0_done");
        bus_rd(8'h03, d8, d0); check("neg_result", d8, 32'hffff_fa00);
        bus_wr(8'h00, 32'h3);
        wait_done("relu1_done");
        bus_rd(8'h03, d8, d0); check("relu_result", d8, 0); check("relu_result_f0", d0, 0);

        // Saturation
        bus_wr(8'h00, 32'h0);
        bus_wr(8'h02, 64);
        for (int i = 0; i < DEPTH; i++) begin
            bus_wr(8'h40 + 8'(i), 32767);
            bus_wr(8'h80 + 8'(i), 32767);
        end
        bus_wr(8'h00, 32'h1);
        wait_done("sat_pos_done");
        bus_rd(8'h03, d8, d0);
        check("sat_pos_f8", d8, 268419072);
        check("sat_pos_f0", d0, 32'h7fff_ffff);
        for (int i = 0; i < DEPTH; i++) bus_wr(8'h80 + 8'(i), 32'h8000);
        bus_wr(8'h00, 32'h1);
        wait_done("sat_neg_done");
        bus_rd(8'h03, d8, d0);
        check("sat_neg_f8", d8, 32'(-268427264));
        check("sat_neg_f0", d0, 32'h8000_0000);

        // Busy lockout
        bus_wr(8'h02, 16);
        bus_wr(8'h00, 32'h1);
        idle(3);
        bus_wr(8'h40, 5);
        bus_wr(8'h00, 32'h5);
        s8 = 0;
        for (int k = 0; k < 100; k++) begin
            if (irq8) begin s8 = 1; break; end
            @(posedge clk); #1;
        end
        check("irq_rise", s8, 1);
        bus_rd(8'h01, d8, d0); check("lock_done", d8, 32'h2);
        idle(40);
        bus_rd(8'h01, d8, d0); check("lock_single_done", d8, 0);
        bus_rd(8'h40, d8, d0); check("lock_x0", d8, 32767);
        bus_rd(8'h03, d8, d0);
        check("lock_result", d8, 32'(-67106816));

        // Edge cases
        bus_wr(8'h02, 0);
        bus_wr(8'h00, 32'h1);
        bus_rd(8'h01, d8, d0); check("len0_busy", d8, 32'h1);
        bus_rd(8'h01, d8, d0); check("len0_done", d8, 32'h2);
        bus_rd(8'h03, d8, d0); check("len0_result", d8, 0);
        bus_wr(8'h02, 300);
        bus_rd(8'h02, d8, d0); check("len_clamp", d8, 64);

        // Randomized traffic, checked by the model/compare process
        for (int it = 0; it < 2500; it++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 6))
                0: a = 8'h00;
                1: a = 8'h01;
                2: a = 8'h02;
                3: a = 8'h03;
                4: a = 8'h40 + 8'($urandom_range(0, 63));
                5: a = 8'h80 + 8'($urandom_range(0, 63));
                default: a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(4, 63))
                                                         : 8'($urandom_range(192, 255));
            endcase
            if (r < 20) begin
                a = (($urandom_range(0, 1) != 0) ? 8'h40 : 8'h80) + 8'($urandom_range(0, 63));
                bus_wr(a, $urandom);
            end else if (r < 28) bus_wr(8'h02, $urandom_range(0, 80));
            else if (r < 36) bus_wr(8'h00, $urandom & 32'h7);
            else if (r < 70) bus_rd(a, d8, d0);
            else if (r < 76) bus_cyc(1, 1, 1, a, $urandom);
            else if (r < 82) bus_cyc(0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                                     a, $urandom);
            else idle(1);
        end

        s8 = 1;
        for (int k = 0; k < 100; k++) begin
            bus_rd(8'h01, d8, d0);
            s8 = d8 & 32'h1;
            if (s8 == 0) break;
        end
        check("random_drain_idle", s8, 0);

        // Reset mid-run
        bus_wr(8'h00, 32'h4);
        bus_wr(8'h02, 64);
        bus_wr(8'h00, 32'h5);
        idle(20);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        bus_rd(8'h01, d8, d0); check("rst_mid_status", d8, 0);
        idle(80);
        bus_rd(8'h01, d8, d0); check("rst_mid_no_done", d8, 0);
        bus_rd(8'h03, d8, d0); check("rst_mid_result", d8, 0);
        check("rst_mid_irq", {31'd0, irq8}, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
